// File: rtl/core_pkg.sv
// core_pkg: shared encodings and FSM state type for the pipeline control blocks
package core_pkg;
    localparam logic [1:0] ALU_SRC = 2'b00;
    localparam logic [1:0] MEM_SRC = 2'b01;
    localparam logic [1:0] PC_SRC  = 2'b10;
    localparam logic [1:0] CSR     = 2'b11;
    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;
    typedef enum logic [1:0] {RUN, MEM_WAIT, MD_BUSY} hz_state_t;
endpackage

// File: rtl/fwd_unit.sv
// fwd_unit: operand forward select for one EX source register
module fwd_unit
    import core_pkg::*;
(
    input  logic [4:0] rs,
    input  logic [4:0] mem_rd,
    input  logic       mem_regWrite,
    input  logic [1:0] mem_regSrc,
    input  logic [4:0] wb_rd,
    input  logic       wb_regWrite,
    output logic [1:0] sel
);
    // MEM wins over WB; a load in MEM has no data yet, so it never forwards
    assign sel = (mem_regWrite && mem_rd != 5'd0 && mem_rd == rs && mem_regSrc != MEM_SRC) ? FWD_MEM :
                 (wb_regWrite && wb_rd != 5'd0 && wb_rd == rs) ? FWD_WB : FWD_RF;
endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: forwarding, stall/flush sequencing, mul/div start and memory timeout for the 5-stage core
module hazard_ctrl
    import core_pkg::*;
#(
    parameter int MEM_TIMEOUT = 64,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic             id_use_rs1,
    input  logic             id_use_rs2,
    input  logic [4:0]       ex_rs1,
    input  logic [4:0]       ex_rs2,
    input  logic [4:0]       ex_rd,
    input  logic             ex_regWrite,
    input  logic [1:0]       ex_regSrc,
    input  logic             ex_md_op,
    input  logic             ex_redirect,
    input  logic [4:0]       mem_rd,
    input  logic             mem_regWrite,
    input  logic [1:0]       mem_regSrc,
    input  logic             mem_req,
    input  logic             dmem_ready,
    input  logic [4:0]       wb_rd,
    input  logic             wb_regWrite,
    input  logic             md_done,
    output logic [1:0]       fwd_a,
    output logic [1:0]       fwd_b,
    output logic             stall_if,
    output logic             stall_id,
    output logic             stall_ex,
    output logic             stall_mem,
    output logic             flush_id,
    output logic             flush_ex,
    output logic             flush_mem,
    output logic             flush_wb,
    output logic             md_start,
    output logic             mem_err,
    output logic [CNT_W-1:0] stall_cycles
);
    localparam int TW = $clog2(MEM_TIMEOUT + 1);

    hz_state_t state, next;
    logic [TW-1:0] tcnt;
    logic md_done_q;
    logic load_use, mem_stall, run, md_hold, md_rel, timeout;

    fwd_unit u_fwd_a (.rs(ex_rs1), .mem_rd, .mem_regWrite, .mem_regSrc, .wb_rd, .wb_regWrite, .sel(fwd_a));
    fwd_unit u_fwd_b (.rs(ex_rs2), .mem_rd, .mem_regWrite, .mem_regSrc, .wb_rd, .wb_regWrite, .sel(fwd_b));

    assign load_use  = ex_regWrite && ex_regSrc == MEM_SRC && ex_rd != 5'd0 &&
                       ((id_use_rs1 && ex_rd == id_rs1) || (id_use_rs2 && ex_rd == id_rs2));
    assign mem_stall = mem_req && !dmem_ready;
    assign run       = !mem_stall && state != MD_BUSY;
    assign md_rel    = state == MD_BUSY && !mem_stall && (md_done || md_done_q);
    assign md_hold   = state == MD_BUSY && !mem_stall && !(md_done || md_done_q);
    assign timeout   = state == MEM_WAIT && mem_stall && tcnt == TW'(MEM_TIMEOUT - 1);

    // state, wait counter, captured md_done, sticky error and stall statistics
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= RUN;
            tcnt         <= '0;
            md_done_q    <= 1'b0;
            mem_err      <= 1'b0;
            stall_cycles <= '0;
        end else begin
            state        <= next;
            tcnt         <= (next == MEM_WAIT) ? ((state == MEM_WAIT) ? tcnt + 1'b1 : TW'(1)) : '0;
            md_done_q    <= state == MD_BUSY && !md_rel && (md_done || md_done_q);
            mem_err      <= mem_err || timeout;
            stall_cycles <= stall_cycles + CNT_W'(stall_if);
        end
    end

    // a memory stall freezes everything except an in-flight mul/div wait, which it overlays
    always_comb begin
        next = mem_stall ? ((state == MD_BUSY) ? MD_BUSY : timeout ? RUN : MEM_WAIT) :
               (state == MD_BUSY) ? (md_rel ? RUN : MD_BUSY) :
               ex_md_op ? MD_BUSY : RUN;
    end

    // outputs are quiet during reset so a mid-wait reset leaves no residual pulse
    always_comb begin
        stall_if  = !rst && (mem_stall || md_hold || (run && (ex_md_op || (!ex_redirect && load_use))));
        stall_id  = stall_if;
        stall_ex  = !rst && (mem_stall || md_hold || (run && ex_md_op));
        stall_mem = !rst && mem_stall;
        flush_wb  = !rst && mem_stall;
        flush_mem = !rst && (md_hold || (run && ex_md_op));
        flush_id  = !rst && run && !ex_md_op && ex_redirect;
        flush_ex  = !rst && run && !ex_md_op && (ex_redirect || load_use);
        md_start  = !rst && run && ex_md_op;
    end
endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: randomized stimulus against a rule-level reference model of hazard_ctrl
module tb_hazard_ctrl;
    localparam int TO = 8;

    logic clk = 1'b0;
    logic rst;
    logic [4:0] id_rs1, id_rs2, ex_rs1, ex_rs2, ex_rd, mem_rd, wb_rd;
    logic id_use_rs1, id_use_rs2, ex_regWrite, ex_md_op, ex_redirect;
    logic mem_regWrite, mem_req, dmem_ready, wb_regWrite, md_done;
    logic [1:0] ex_regSrc, mem_regSrc, fwd_a, fwd_b;
    logic stall_if, stall_id, stall_ex, stall_mem, flush_id, flush_ex, flush_mem, flush_wb;
    logic md_start, mem_err;
    logic [31:0] stall_cycles;

    int tests = 0, fails = 0;

    bit m_wait, m_md, m_seen, m_err;
    int m_len, m_timeouts;
    logic [31:0] m_stalls;
    logic [12:0] exp_vec;

    always #5 clk = ~clk;

    hazard_ctrl #(.MEM_TIMEOUT(TO), .CNT_W(32)) dut (
        .clk, .rst, .id_rs1, .id_rs2, .id_use_rs1, .id_use_rs2, .ex_rs1, .ex_rs2, .ex_rd,
        .ex_regWrite, .ex_regSrc, .ex_md_op, .ex_redirect, .mem_rd, .mem_regWrite, .mem_regSrc,
        .mem_req, .dmem_ready, .wb_rd, .wb_regWrite, .md_done, .fwd_a, .fwd_b,
        .stall_if, .stall_id, .stall_ex, .stall_mem, .flush_id, .flush_ex, .flush_mem, .flush_wb,
        .md_start, .mem_err, .stall_cycles
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [1:0] ref_fwd(input logic [4:0] rs);
        if (mem_regWrite && mem_rd != 0 && mem_rd == rs && mem_regSrc != 2'b01) return 2'b10;
        if (wb_regWrite && wb_rd != 0 && wb_rd == rs) return 2'b01;
        return 2'b00;
    endfunction

    // expected {fwd_a, fwd_b, stall if/id/ex/mem, flush id/ex/mem/wb, md_start}
    function automatic logic [12:0] ref_out();
        logic ms, lu, st;
        logic [3:0] s, f;
        ms = mem_req && !dmem_ready;
        lu = ex_regWrite && ex_regSrc == 2'b01 && ex_rd != 0 &&
             ((id_use_rs1 && ex_rd == id_rs1) || (id_use_rs2 && ex_rd == id_rs2));
        s = 4'b0000; f = 4'b0000; st = 1'b0;
        if (rst) begin
        end else if (ms) begin
            s = 4'b1111; f = 4'b0001;
        end else if (m_md) begin
            if (!(md_done || m_seen)) begin s = 4'b1110; f = 4'b0010; end
        end else if (ex_md_op) begin
            s = 4'b1110; f = 4'b0010; st = 1'b1;
        end else if (ex_redirect) begin
            f = 4'b1100;
        end else if (lu) begin
            s = 4'b1100; f = 4'b0100;
        end
        return {ref_fwd(ex_rs1), ref_fwd(ex_rs2), s, f, st};
    endfunction

    task automatic model_step();
        logic ms;
        ms = mem_req && !dmem_ready;
        if (rst) begin
            m_wait = 0; m_md = 0; m_seen = 0; m_err = 0; m_len = 0; m_stalls = 0;
        end else begin
            if (exp_vec[8]) m_stalls = m_stalls + 1;
            if (ms) begin
                if (m_md) m_seen = m_seen || md_done;
                else if (m_wait) begin
                    m_len++;
                    if (m_len == TO) begin m_err = 1; m_wait = 0; m_timeouts++; end
                end else begin
                    m_wait = 1; m_len = 1;
                end
            end else begin
                m_wait = 0;
                if (m_md) begin
                    if (md_done || m_seen) begin m_md = 0; m_seen = 0; end
                end else if (ex_md_op) m_md = 1;
            end
        end
    endtask

    task automatic drive(input int c, input int req_pct, input int rdy_pct);
        rst          = (c < 2) || ($urandom_range(0, 199) == 0);
        id_rs1       = 5'($urandom_range(0, 3));
        id_rs2       = 5'($urandom_range(0, 3));
        ex_rs1       = 5'($urandom_range(0, 3));
        ex_rs2       = 5'($urandom_range(0, 3));
        ex_rd        = 5'($urandom_range(0, 3));
        mem_rd       = 5'($urandom_range(0, 3));
        wb_rd        = 5'($urandom_range(0, 3));
        id_use_rs1   = $urandom_range(0, 9) < 7;
        id_use_rs2   = $urandom_range(0, 9) < 7;
        ex_regWrite  = $urandom_range(0, 9) < 7;
        mem_regWrite = $urandom_range(0, 9) < 7;
        wb_regWrite  = $urandom_range(0, 9) < 7;
        ex_regSrc    = 2'($urandom_range(0, 3));
        mem_regSrc   = 2'($urandom_range(0, 3));
        ex_md_op     = $urandom_range(0, 99) < 15;
        ex_redirect  = $urandom_range(0, 99) < 20;
        md_done      = $urandom_range(0, 99) < 15;
        mem_req      = $urandom_range(0, 99) < req_pct;
        dmem_ready   = $urandom_range(0, 99) < rdy_pct;
    endtask

    initial begin
        int c;
        m_wait = 0; m_md = 0; m_seen = 0; m_err = 0; m_len = 0; m_timeouts = 0; m_stalls = 0;
        c = 0;
        for (int p = 0; p < 3; p++) begin
            for (int k = 0; k < 2000; k++) begin
                @(negedge clk);
                if (c > 0) begin
                    check("stall_cycles", 64'(stall_cycles), 64'(m_stalls));
                    check("mem_err", 64'(mem_err), 64'(m_err));
                end
                drive(c, (p == 2) ? 95 : 40, (p == 0) ? 70 : (p == 1) ? 25 : 0);
                #1;
                exp_vec = ref_out();
                check("outputs", 64'({fwd_a, fwd_b, stall_if, stall_id, stall_ex, stall_mem,
                                       flush_id, flush_ex, flush_mem, flush_wb, md_start}), 64'(exp_vec));
                @(posedge clk);
                model_step();
                c++;
            end
        end
        @(negedge clk);
        check("stall_cycles_end", 64'(stall_cycles), 64'(m_stalls));
        check("mem_err_end", 64'(mem_err), 64'(m_err));
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
